calendar_date_engine: RTL

//  Parametrised date keeper and LCD frame generator for the clock/calendar term design.

---
 rtl/calendar_date_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/calendar_date_engine.sv
// calendar_date_engine: BCD date keeper with Gregorian rollover, validated loads and a 34-entry HD44780 frame stream
module calendar_date_engine #(
  parameter int                       YEAR_DIGITS = 4,
  parameter logic [4*YEAR_DIGITS-1:0] RESET_YEAR  = 16'h2020,
  parameter logic [2:0]               RESET_DOW   = 3'd3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     DAY_TICK,
  input  logic                     SET_LOAD,
  input  logic [4*YEAR_DIGITS-1:0] SET_YEAR,
  input  logic [3:0]               SET_MONTH,
  input  logic [4:0]               SET_DAY,
  input  logic [2:0]               SET_DOW,
  input  logic                     DISP_EN,
  input  logic                     LCD_READY,
  output logic                     LCD_VALID,
  output logic                     LCD_RS,
  output logic                     LCD_RW,
  output logic [7:0]               LCD_DATA,
  output logic                     FRAME_DONE,
  output logic [4*YEAR_DIGITS-1:0] YEAR_BCD,
  output logic [3:0]               MONTH,
  output logic [4:0]               DAY,
  output logic [2:0]               DOW,
  output logic                     LEAP,
  output logic                     SET_ERR
);
  localparam int YW = 4*YEAR_DIGITS;
  localparam int LPAD = (16-(YEAR_DIGITS+6))>>1;
  localparam logic [79:0] HDR = " Today is ";
  function automatic logic div4(input logic [3:0] t, input logic [3:0] o);
    return t[0] ? (o == 4'd2 || o == 4'd6) : (o == 4'd0 || o == 4'd4 || o == 4'd8);
  endfunction
  function automatic logic is_leap(input logic [YW-1:0] y);
    return (y[7:0] == 8'h00) ? div4(y[15:12], y[11:8]) : div4(y[7:4], y[3:0]);
  endfunction
  function automatic logic [4:0] mlen(input logic [3:0] m, input logic lp);
    return (m == 4'd2) ? (lp ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  function automatic logic [YW-1:0] yinc(input logic [YW-1:0] y);
    logic [YW-1:0] r;
    logic c;
    r = y;
    c = 1'b1;
    for (int k = 0; k < YEAR_DIGITS; k++)
      if (c) begin
        c = (r[4*k +: 4] == 4'd9);
        r[4*k +: 4] = c ? 4'd0 : r[4*k +: 4] + 4'd1;
      end
    return r;
  endfunction
  function automatic logic ydig_ok(input logic [YW-1:0] y);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < YEAR_DIGITS; k++) ok = ok & (y[4*k +: 4] <= 4'd9);
    return ok;
  endfunction
  function automatic logic [23:0] dname(input logic [2:0] w);
    return w == 3'd0 ? "SUN" : w == 3'd1 ? "MON" : w == 3'd2 ? "TUE" :
           w == 3'd3 ? "WED" : w == 3'd4 ? "THU" : w == 3'd5 ? "FRI" : "SAT";
  endfunction
  function automatic logic [15:0] bin2asc(input logic [4:0] v);
    logic [1:0] t;
    t = v >= 5'd30 ? 2'd3 : v >= 5'd20 ? 2'd2 : v >= 5'd10 ? 2'd1 : 2'd0;
    return {6'b001100, t, 4'h3, 4'(v - 5'd10 * {3'b000, t})};
  endfunction
  // Returns {RS, DATA} for frame entry i built from the frozen date snapshot.
  function automatic logic [8:0] entry(input logic [5:0] i, input logic [YW-1:0] y,
                                       input logic [3:0] m, input logic [4:0] d, input logic [2:0] w);
    logic [7:0] c;
    logic [23:0] dn;
    logic [15:0] ma, da;
    int p, q;
    dn = dname(w);
    ma = bin2asc({1'b0, m});
    da = bin2asc(d);
    p = int'(i) - 1;
    q = int'(i) - 18 - LPAD;
    c = 8'h20;
    if (i == 6'd0 || i == 6'd17) return {1'b0, (i == 6'd0) ? 8'h80 : 8'hC0};
    if (i < 6'd17) begin
      if (p < 10) c = HDR[8*(9-p) +: 8];
      else if (p < 13) c = dn[8*(12-p) +: 8];
    end else if (q >= 0 && q < YEAR_DIGITS) c = {4'h3, y[4*(YEAR_DIGITS-1-q) +: 4]};
    else if (q == YEAR_DIGITS || q == YEAR_DIGITS+3) c = 8'h2D;
    else if (q == YEAR_DIGITS+1) c = ma[15:8];
    else if (q == YEAR_DIGITS+2) c = ma[7:0];
    else if (q == YEAR_DIGITS+4) c = da[15:8];
    else if (q == YEAR_DIGITS+5) c = da[7:0];
    return {1'b1, c};
  endfunction
  logic [YW-1:0] year_q, year_d, sy_q, sy_d;
  logic [3:0] month_q, month_d, sm_q, sm_d;
  logic [4:0] day_q, day_d, sd_q, sd_d, cur_len;
  logic [2:0] dow_q, dow_d, sw_q, sw_d;
  logic err_q, err_d, set_ok;
  logic vld_q, vld_d, rs_q, rs_d, rw_q, rw_d, fd_q, fd_d, acc;
  logic [7:0] data_q, data_d;
  logic [5:0] idx_q, idx_d;
  logic [8:0] ent;
  assign LEAP = is_leap(year_q);
  assign cur_len = mlen(month_q, LEAP);
  assign set_ok = ydig_ok(SET_YEAR) && SET_MONTH >= 4'd1 && SET_MONTH <= 4'd12 && SET_DAY >= 5'd1 &&
                  SET_DAY <= mlen(SET_MONTH, is_leap(SET_YEAR)) && SET_DOW <= 3'd6;
  always_comb begin
    year_d = year_q;
    month_d = month_q;
    day_d = day_q;
    dow_d = dow_q;
    err_d = 1'b0;
    if (SET_LOAD) begin
      err_d = !set_ok;
      if (set_ok) begin
        year_d = SET_YEAR;
        month_d = SET_MONTH;
        day_d = SET_DAY;
        dow_d = SET_DOW;
      end
    end else if (DAY_TICK) begin
      dow_d = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
      day_d = (day_q >= cur_len) ? 5'd1 : day_q + 5'd1;
      if (day_q >= cur_len) begin
        month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
        if (month_q == 4'd12) year_d = yinc(year_q);
      end
    end
  end
  // Pins are registered, so they are computed for the index the next cycle will hold.
  always_comb begin
    acc = vld_q & LCD_READY;
    idx_d = !DISP_EN ? 6'd0 : acc ? ((idx_q == 6'd33) ? 6'd0 : idx_q + 6'd1) : idx_q;
    fd_d = acc && idx_q == 6'd33;
    sy_d = (idx_q == 6'd0) ? year_q : sy_q;
    sm_d = (idx_q == 6'd0) ? month_q : sm_q;
    sd_d = (idx_q == 6'd0) ? day_q : sd_q;
    sw_d = (idx_q == 6'd0) ? dow_q : sw_q;
    ent = entry(idx_d, sy_d, sm_d, sd_d, sw_d);
    vld_d = DISP_EN;
    rs_d = DISP_EN ? ent[8] : 1'b1;
    rw_d = !DISP_EN;
    data_d = DISP_EN ? ent[7:0] : 8'h02;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      year_q <= RESET_YEAR;
      month_q <= 4'd1;
      day_q <= 5'd1;
      dow_q <= RESET_DOW;
      err_q <= 1'b0;
      sy_q <= RESET_YEAR;
      sm_q <= 4'd1;
      sd_q <= 5'd1;
      sw_q <= RESET_DOW;
      vld_q <= 1'b0;
      rs_q <= 1'b1;
      rw_q <= 1'b1;
      data_q <= 8'h02;
      idx_q <= 6'd0;
      fd_q <= 1'b0;
    end else begin
      year_q <= year_d;
      month_q <= month_d;
      day_q <= day_d;
      dow_q <= dow_d;
      err_q <= err_d;
      sy_q <= sy_d;
      sm_q <= sm_d;
      sd_q <= sd_d;
      sw_q <= sw_d;
      vld_q <= vld_d;
      rs_q <= rs_d;
      rw_q <= rw_d;
      data_q <= data_d;
      idx_q <= idx_d;
      fd_q <= fd_d;
    end
  end
  assign YEAR_BCD = year_q;
  assign MONTH = month_q;
  assign DAY = day_q;
  assign DOW = dow_q;
  assign SET_ERR = err_q;
  assign LCD_VALID = vld_q;
  assign LCD_RS = rs_q;
  assign LCD_RW = rw_q;
  assign LCD_DATA = data_q;
  assign FRAME_DONE = fd_q;
endmodule
